yarp_muldiv_seq: RTL and testbench
==================================

YARP_MULDIV_SEQ -- requirements
Module: yarp_muldiv_seq

Interface
REQ-001 SHALL have a single clock `clk`, input, 1 bit; all state updates on its rising edge.
REQ-002 SHALL have reset `reset_n`, input, 1 bit; synchronous, active-low.
REQ-003 SHALL have `req_valid_i`, input, 1 bit: a request is presented.
REQ-004 SHALL have `req_ready_o`, output, 1 bit: the block can accept a request.
REQ-005 SHALL have `op_i`, input, 2 bits, type `muldiv_op_t`: MUL=0, MULHU=1, DIVU=2, REMU=3.
REQ-006 SHALL have `opr_a_i` / `opr_b_i`, inputs, 32 bits each: multiplicand/multiplier, or dividend/divisor.
REQ-007 SHALL have `flush_i`, input, 1 bit: abort the current operation.
REQ-008 SHALL have `res_valid_o` (output, 1), `res_ready_i` (input, 1) and `res_o` (output, 32): the result channel.
REQ-009 SHALL have `busy_o`, output, 1 bit: high whenever state is not IDLE.
REQ-010 SHALL have `alu_opr_a_o` / `alu_opr_b_o`, outputs, 32 bits: operands driven to the shared ALU.
REQ-011 SHALL have `alu_op_sel_o`, output, 4 bits: ALU op code from the yarp_pkg ALU enum.
REQ-012 SHALL have `alu_res_i`, input, 32 bits: combinational result returned by the shared ALU.

Function
REQ-013 SHALL implement states IDLE, CALC and DONE.
REQ-014 SHALL drive `req_ready_o` = (state == IDLE); a request is accepted on a clock edge where req_valid_i && req_ready_o.
REQ-015 SHALL, on accept, latch op_i and the operands, clear the 6-bit step counter, and go IDLE -> CALC.
REQ-016 SHALL, for MUL/MULHU, run 32 shift-add steps:
- registers: hi (starts 0), lo (starts opr_b), mcand (opr_a);
- each step drives ALU ADD with hi and mcand;
- if lo[0], add is used: sum = alu_res_i, carry = (alu_res_i < hi) unsigned; otherwise sum = hi, carry = 0;
- then {hi, lo} <= {carry, sum, lo} >> 1.
REQ-017 SHALL, for DIVU/REMU, run 32 restoring steps:
- registers: rem (starts 0), q (starts opr_a);
- sh = {rem[30:0], q[31]}; ALU SUB with sh and divisor;
- if rem[31] || sh >= divisor: rem <= alu_res_i, new quotient bit = 1; otherwise rem <= sh, new quotient bit = 0;
- q <<= 1, with the new quotient bit in q[0].
REQ-018 SHALL go CALC -> DONE after step 32; accept at edge N gives res_valid_o high from cycle N+33.
REQ-019 SHALL select `res_o` as MUL = lo, MULHU = hi, DIVU = q, REMU = rem; res_o SHALL be 0 outside DONE.
REQ-020 SHALL hold res_valid_o and res_o stable in DONE until res_ready_i; on that handshake, go DONE -> IDLE.
REQ-021 SHALL produce, for a divisor of 0 via the normal loop: DIVU = 0xFFFFFFFF, REMU = dividend.
REQ-022 SHALL, on `flush_i` in CALC or DONE, go to IDLE next edge and discard the result.
- flush wins over a simultaneous result handshake.
- flush in IDLE has no effect; it does not block a same-cycle accept.
REQ-023 SHALL drive ALU outputs of op ADD with operands 0 when not in CALC.

Reset
REQ-024 SHALL, on reset_n low at an edge, set state IDLE, counter 0 and all datapath registers 0, including mid-operation.
REQ-025 SHALL have these reset output values: req_ready_o=1, res_valid_o=0, res_o=0, busy_o=0, alu_op_sel_o=ADD, ALU operands 0.

Configuration
REQ-026 SHALL support the macro `YARP_MULDIV_EARLY_OUT_EN`:
- defined: on accept, when a MUL/MULHU operand is 0 or a DIVU/REMU divisor is 0, go IDLE -> DONE directly with the REQ-019/021 result; res_valid_o is high at N+1.
- undefined: every operation takes the full 32 steps.

Structure
REQ-027 SHALL place `muldiv_op_t`, the state enum `muldiv_state_t` and the constant MULDIV_STEPS=32 in yarp_pkg, reusing the existing ADD/SUB ALU codes.
REQ-028 SHALL NOT instantiate the ALU; yarp_execute is shared and muxed outside. No sub-module is required.

Verification
REQ-029 SHALL cover MUL 7 x 6 -> res_o=42, res_valid_o at accept+33.
REQ-030 SHALL cover MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL of the same operands -> 0x00000001.
REQ-031 SHALL cover DIVU 100/7 -> 14 and REMU 100/7 -> 2; DIVU 0x80000000/1 -> 0x80000000.
REQ-032 SHALL cover DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, checking 33-cycle latency without the macro and 1-cycle latency with it.
REQ-033 SHALL cover res_ready_i held low 10 cycles -> res_valid_o and res_o stable, req_ready_o low, then one handshake -> IDLE.
REQ-034 SHALL cover flush_i at step 15 -> IDLE next cycle, no res_valid_o; reset_n low mid-CALC -> REQ-025 values; a new request then completes correctly.

Source files
------------

// File: rtl/yarp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : yarp_pkg
// Description : Shared YARP types: ALU op codes plus the sequential mul/div
//               operation and state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package yarp_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'h0,
        SUB  = 4'h1,
        SLL  = 4'h2,
        SRL  = 4'h3,
        SRA  = 4'h4,
        OR   = 4'h5,
        AND  = 4'h6,
        XOR  = 4'h7,
        SLTU = 4'h8,
        SLT  = 4'h9
    } alu_op_t;

    typedef enum logic [1:0] {
        MUL   = 2'd0,
        MULHU = 2'd1,
        DIVU  = 2'd2,
        REMU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    localparam int MULDIV_STEPS = 32;

endpackage
`default_nettype wire

// File: rtl/yarp_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : yarp_muldiv_seq
// Description : 32-step shift-add multiplier / restoring divider that borrows
//               the shared execute ALU. Optional YARP_MULDIV_EARLY_OUT_EN
//               finishes zero-operand cases straight from IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module yarp_muldiv_seq
    import yarp_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  muldiv_op_t  op_i,
    input  logic [31:0] opr_a_i,
    input  logic [31:0] opr_b_i,
    input  logic        flush_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_o,
    output logic        busy_o,
    output logic [31:0] alu_opr_a_o,
    output logic [31:0] alu_opr_b_o,
    output logic [3:0]  alu_op_sel_o,
    input  logic [31:0] alu_res_i
);

    muldiv_state_t r_state, w_next;
    muldiv_op_t    r_op;
    logic [5:0]    r_cnt;
    // r_acc holds hi (mul) or rem (div); r_lo holds lo or q; r_b holds mcand or divisor
    logic [31:0]   r_acc, r_lo, r_b;

    logic          w_accept, w_is_mul, w_in_mul, w_last, w_early;
    logic [31:0]   w_sum, w_sh;
    logic          w_carry, w_take;

    assign w_accept = req_valid_i && req_ready_o;
    assign w_is_mul = (r_op == MUL) || (r_op == MULHU);
    assign w_in_mul = (op_i == MUL) || (op_i == MULHU);
    assign w_last   = (r_cnt == 6'(MULDIV_STEPS - 1));

`ifdef YARP_MULDIV_EARLY_OUT_EN
    assign w_early = w_in_mul ? ((opr_a_i == 32'd0) || (opr_b_i == 32'd0))
                              : (opr_b_i == 32'd0);
`else
    assign w_early = 1'b0;
`endif

    // Multiply step: conditional add with carry recovered from the 32-bit sum
    assign w_sum   = r_lo[0] ? alu_res_i : r_acc;
    assign w_carry = r_lo[0] && (alu_res_i < r_acc);

    // Divide step: the 33-bit partial remainder is {r_acc[31], w_sh}
    assign w_sh    = {r_acc[30:0], r_lo[31]};
    assign w_take  = r_acc[31] || (w_sh >= r_b);

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_early ? DONE : CALC;
            CALC:    if (flush_i) w_next = IDLE;
                     else if (w_last) w_next = DONE;
            DONE:    if (flush_i || res_ready_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_op  <= MUL;
            r_cnt <= 6'd0;
            r_acc <= 32'd0;
            r_lo  <= 32'd0;
            r_b   <= 32'd0;
        end else if (w_accept) begin
            r_op  <= op_i;
            r_cnt <= 6'd0;
            r_acc <= 32'd0;
            r_lo  <= w_in_mul ? opr_b_i : opr_a_i;
            r_b   <= w_in_mul ? opr_a_i : opr_b_i;
`ifdef YARP_MULDIV_EARLY_OUT_EN
            if (w_early) begin
                r_acc <= w_in_mul ? 32'd0 : opr_a_i;
                r_lo  <= w_in_mul ? 32'd0 : 32'hFFFF_FFFF;
            end
`endif
        end else if ((r_state == CALC) && !flush_i) begin
            r_cnt <= r_cnt + 6'd1;
            if (w_is_mul) begin
                r_acc <= {w_carry, w_sum[31:1]};
                r_lo  <= {w_sum[0], r_lo[31:1]};
            end else begin
                r_acc <= w_take ? alu_res_i : w_sh;
                r_lo  <= {r_lo[30:0], w_take};
            end
        end
    end

    always_comb begin
        alu_op_sel_o = ADD;
        alu_opr_a_o  = 32'd0;
        alu_opr_b_o  = 32'd0;
        if (r_state == CALC) begin
            alu_op_sel_o = w_is_mul ? ADD : SUB;
            alu_opr_a_o  = w_is_mul ? r_acc : w_sh;
            alu_opr_b_o  = r_b;
        end
    end

    always_comb begin
        res_o = 32'd0;
        if (r_state == DONE) begin
            case (r_op)
                MUL:     res_o = r_lo;
                MULHU:   res_o = r_acc;
                DIVU:    res_o = r_lo;
                default: res_o = r_acc;
            endcase
        end
    end

    assign req_ready_o = (r_state == IDLE);
    assign busy_o      = (r_state != IDLE);
    assign res_valid_o = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_yarp_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_yarp_muldiv_seq
// Description : Directed bench for yarp_muldiv_seq with a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_yarp_muldiv_seq;
    import yarp_pkg::*;

`ifdef YARP_MULDIV_EARLY_OUT_EN
    localparam int c_zero_lat = 1;
`else
    localparam int c_zero_lat = 33;
`endif
    localparam int c_full_lat = 33;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    muldiv_op_t  op = MUL;
    logic [31:0] opr_a = 32'd0;
    logic [31:0] opr_b = 32'd0;
    logic        flush = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res;
    logic        busy;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic [31:0] alu_res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Shared ALU stand-in
    assign alu_res = (alu_sel == 4'(ADD)) ? alu_a + alu_b :
                     (alu_sel == 4'(SUB)) ? alu_a - alu_b : 32'd0;

    yarp_muldiv_seq dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .op_i         (op),
        .opr_a_i      (opr_a),
        .opr_b_i      (opr_b),
        .flush_i      (flush),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_o        (res),
        .busy_o       (busy),
        .alu_opr_a_o  (alu_a),
        .alu_opr_b_o  (alu_b),
        .alu_op_sel_o (alu_sel),
        .alu_res_i    (alu_res)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, " res"}, res, 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " alu_sel"}, 32'(alu_sel), 32'(ADD));
        chk({tag, " alu_a"}, alu_a, 32'd0);
        chk({tag, " alu_b"}, alu_b, 32'd0);
    endtask

    task automatic issue(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                         input bit fl);
        op = o; opr_a = a; opr_b = b; req_valid = 1'b1; flush = fl;
        tick();
        req_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic run_op(input string tag, input muldiv_op_t o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_lat, input bit fl);
        int  lat;
        bit  is_mul;
        is_mul = (o == MUL) || (o == MULHU);
        issue(o, a, b, fl);
        lat = 1;
        if (exp_lat > 1) begin
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " alu_sel"}, 32'(alu_sel), is_mul ? 32'(ADD) : 32'(SUB));
            chk({tag, " alu_b"}, alu_b, is_mul ? a : b);
        end
        while (!res_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " res"}, res, exp);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, " back_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        bit saw_valid;
        repeat (3) tick();
        chk_idle("reset");
        reset_n = 1'b1;
        tick();

        run_op("mul7x6",   MUL,   32'd7, 32'd6, 32'd42, c_full_lat, 1'b0);
        run_op("mulhu_ff", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, c_full_lat, 1'b0);
        run_op("mul_ff",   MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, c_full_lat, 1'b0);
        run_op("divu100",  DIVU,  32'd100, 32'd7, 32'd14, c_full_lat, 1'b0);
        run_op("remu100",  REMU,  32'd100, 32'd7, 32'd2, c_full_lat, 1'b0);
        run_op("divu_msb", DIVU,  32'h8000_0000, 32'd1, 32'h8000_0000, c_full_lat, 1'b0);
        run_op("divu_z",   DIVU,  32'd5, 32'd0, 32'hFFFF_FFFF, c_zero_lat, 1'b0);
        run_op("remu_z",   REMU,  32'd5, 32'd0, 32'd5, c_zero_lat, 1'b0);
        chk_idle("after_ops");

        // Result held while the consumer stalls
        issue(MUL, 32'd7, 32'd6, 1'b0);
        repeat (32) tick();
        chk("stall valid", 32'(res_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall hold_valid", 32'(res_valid), 32'd1);
            chk("stall hold_res", res, 32'd42);
            chk("stall req_ready", 32'(req_ready), 32'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk_idle("stall_release");

        // Flush partway through the loop
        issue(DIVU, 32'd100, 32'd7, 1'b0);
        repeat (14) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_idle("flush");
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (res_valid) saw_valid = 1'b1;
        end
        chk("flush no_result", 32'(saw_valid), 32'd0);
        run_op("after_flush", REMU, 32'd100, 32'd7, 32'd2, c_full_lat, 1'b0);

        // Flush while idle must not block the accept
        run_op("idle_flush", MULHU, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, c_full_lat, 1'b1);

        // Flush in DONE wins over the handshake and clears the result
        issue(DIVU, 32'd9, 32'd3, 1'b0);
        repeat (32) tick();
        chk("done_flush valid", 32'(res_valid), 32'd1);
        flush = 1'b1; res_ready = 1'b1;
        tick();
        flush = 1'b0; res_ready = 1'b0;
        chk_idle("done_flush");

        // Reset in the middle of a calculation
        issue(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (10) tick();
        reset_n = 1'b0;
        tick();
        chk_idle("mid_reset");
        reset_n = 1'b1;
        tick();
        run_op("post_reset", MUL, 32'd7, 32'd6, 32'd42, c_full_lat, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
